// File: rtl/rsp_lden_pkg.sv
// Shared sizing and state encoding for the RSP latch register-file write controller.
package rsp_lden_pkg;

  localparam int unsigned RSP_RF_ENTRIES = 32;
  localparam int unsigned RSP_RF_AW      = 5;
  localparam int unsigned RSP_RF_DW      = 32;

  typedef enum logic {
    CLEAR,
    RUN
  } lden_state_t;

endpackage

// File: rtl/rsp_lden32_wctl_if.sv
// Requester handshakes plus the register-file write port of rsp_lden32_wctl.
interface rsp_lden32_wctl_if;
  import rsp_lden_pkg::*;

  logic                      su_req;
  logic [RSP_RF_AW-1:0]      su_addr;
  logic [RSP_RF_DW-1:0]      su_data;
  logic                      su_gnt;
  logic                      dma_req;
  logic [RSP_RF_AW-1:0]      dma_addr;
  logic [RSP_RF_DW-1:0]      dma_data;
  logic                      dma_gnt;
  logic [RSP_RF_ENTRIES-1:0] wr_ld_bar;
  logic [RSP_RF_DW-1:0]      wr_data;
  logic                      clr_done;

  // Requesters and the register-file side.
  modport master (
    output su_req, su_addr, su_data, dma_req, dma_addr, dma_data,
    input  su_gnt, dma_gnt, wr_ld_bar, wr_data, clr_done
  );

  // The write controller.
  modport slave (
    input  su_req, su_addr, su_data, dma_req, dma_addr, dma_data,
    output su_gnt, dma_gnt, wr_ld_bar, wr_data, clr_done
  );

endinterface

// File: rtl/rsp_lden32_dec.sv
// 5-to-32 active-low one-hot load decoder; entry 0 is hardwired zero and never loads.
module rsp_lden32_dec
  import rsp_lden_pkg::*;
(
  input  logic                      en,
  input  logic [RSP_RF_AW-1:0]      addr,
  output logic [RSP_RF_ENTRIES-1:0] ld_bar
);

  // Drive a single low bit for the addressed entry when enabled.
  always_comb begin
    ld_bar = '1;
    if (en && (addr != '0)) begin
      ld_bar[addr] = 1'b0;
    end
  end

endmodule

// File: rtl/rsp_lden32_wctl.sv
// Write-port controller: post-reset clear walk of entries 1..31, then su/dma
// arbitration with dma starvation protection, registered one-hot load vector.
module rsp_lden32_wctl
  import rsp_lden_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset_l,
  input  logic                hold,
  rsp_lden32_wctl_if.slave    bus
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [RSP_RF_AW-1:0] LAST_PTR = RSP_RF_AW'(RSP_RF_ENTRIES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  lden_state_t               state_q, state_d;
  logic [RSP_RF_AW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]             starve_q, starve_d;
  logic [RSP_RF_ENTRIES-1:0] ld_bar_q, ld_bar_d;
  logic [RSP_RF_DW-1:0]      data_q, data_d;

  logic                      su_gnt, dma_gnt, dma_force;
  logic                      dec_en;
  logic [RSP_RF_AW-1:0]      dec_addr;

  // One decoder serves both the clear pointer and the granted run address.
  rsp_lden32_dec u_dec (
    .en     (dec_en),
    .addr   (dec_addr),
    .ld_bar (ld_bar_d)
  );

  // Next-state, arbitration, starvation counter and write-issue selection.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    starve_d  = starve_q;
    data_d    = data_q;
    su_gnt    = 1'b0;
    dma_gnt   = 1'b0;
    dma_force = 1'b0;
    dec_en    = 1'b0;
    dec_addr  = ptr_q;
    unique case (state_q)
      CLEAR: begin
        if (!hold) begin
          dec_en   = 1'b1;
          dec_addr = ptr_q;
          data_d   = '0;
          ptr_d    = ptr_q + RSP_RF_AW'(1);
          if (ptr_q == LAST_PTR) state_d = RUN;
        end
      end
      RUN: begin
        if (!hold) begin
          dma_force = (starve_q >= CW'(STARVE_LIMIT));
          su_gnt    = bus.su_req & ~(dma_force & bus.dma_req);
          dma_gnt   = bus.dma_req & ~su_gnt;
          if (su_gnt) begin
            dec_en   = 1'b1;
            dec_addr = bus.su_addr;
            data_d   = bus.su_data;
          end else if (dma_gnt) begin
            dec_en   = 1'b1;
            dec_addr = bus.dma_addr;
            data_d   = bus.dma_data;
          end
          if (dma_gnt || !bus.dma_req) begin
            starve_d = '0;
          end else if (su_gnt && starve_q != CNT_MAX) begin
            starve_d = starve_q + CW'(1);
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // State and output registers; reset drops any in-flight write and restarts the walk.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= CLEAR;
      ptr_q    <= RSP_RF_AW'(1);
      starve_q <= '0;
      ld_bar_q <= '1;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      starve_q <= starve_d;
      ld_bar_q <= ld_bar_d;
      data_q   <= data_d;
    end
  end

  assign bus.su_gnt    = su_gnt;
  assign bus.dma_gnt   = dma_gnt;
  assign bus.wr_ld_bar = ld_bar_q;
  assign bus.wr_data   = data_q;
  assign bus.clr_done  = (state_q == RUN);

endmodule

// File: doc/rsp_lden32_wctl.md
# rsp_lden32_wctl

Write-port controller for the RSP 32-entry latch register file. It arbitrates two write requesters, the scalar-unit writeback (su) and DMA load (dma), onto the file's single write port. It produces the registered active-low one-hot load vector that the per-entry clock-gating OR cells consume. After reset it sequences a zero-clear of entries 1..31 before accepting requests.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive su wins, while dma is waiting, before dma is forced a grant.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset_l  in  1  asynchronous, active-low reset.
- hold  in  1  pipeline stall; blocks grants and the clear walk.
- su_req  in  1  su write request; held until granted.
- su_addr  in  5  su target entry.
- su_data  in  32  su write data.
- su_gnt  out  1  combinational grant; request consumed at this edge.
- dma_req / dma_addr / dma_data / dma_gnt: same as the su set, for dma.
- wr_ld_bar  out  32  registered active-low one-hot load enable; all-ones means no write.
- wr_data  out  32  registered write data, aligned with wr_ld_bar.
- clr_done  out  1  high once the clear walk is complete (state RUN).

## Operation
- States:
  - CLEAR, entered on reset.
  - RUN, terminal until the next reset.
- CLEAR:
  - Pointer ptr starts at 1.
  - Each edge with hold=0: wr_ld_bar<=~(1<<ptr), wr_data<=0, ptr++.
  - On the edge that writes ptr=31, next state is RUN.
  - hold=1: ptr frozen, wr_ld_bar<=all-ones.
  - Both gnts are 0 throughout.
- RUN arbitration, combinational, with hold=0:
  - dma_force = (starve_cnt >= STARVE_LIMIT).
  - su_gnt = su_req & ~(dma_force & dma_req).
  - dma_gnt = dma_req & ~su_gnt.
  - At most one grant per cycle.
- Starvation counter (width $clog2(STARVE_LIMIT+1), saturating):
  - Increments when dma_req & su_gnt.
  - Clears when dma_gnt or ~dma_req.
  - Holds while hold=1.
- Write issue: on the grant edge, wr_ld_bar<=~(1<<addr) and wr_data<=data of the granted requester. With no grant, wr_ld_bar<=all-ones and wr_data holds its value.
- Entry 0 is hardwired zero. An addr=0 request is still granted (consumed), but wr_ld_bar stays all-ones.
- hold=1 in RUN: both gnts 0, wr_ld_bar<=all-ones.
- Same-address requests from both requesters: ordinary arbitration; the loser writes in a later cycle, so last-granted wins.

## Timing
- Reset values (asynchronous):
  - state=CLEAR, ptr=1, starve_cnt=0.
  - wr_ld_bar=32'hFFFF_FFFF, wr_data=0.
  - su_gnt=dma_gnt=0, clr_done=0.
- Clear duration: cycles 1..31 after reset release, with no hold. clr_done=1 from cycle 32; grants are possible from cycle 32.
- Write latency: 1 cycle from grant to wr_ld_bar/wr_data.
- wr_ld_bar is launched at the rising edge and is stable through the following clk-low phase, when the gated enable is open.
- Back-to-back grants produce back-to-back one-hot vectors with no idle cycle.
- reset_l asserted mid-clear or mid-write: immediate return to the reset values. Any in-flight write is dropped, and the clear restarts at ptr=1.
- Requesters must keep req/addr/data stable until gnt. A req deasserted without a grant is legal (the request is withdrawn).

## Structure
- Package rsp_lden_pkg:
  - RSP_RF_ENTRIES=32.
  - RSP_RF_AW=5.
  - RSP_RF_DW=32.
  - Enum lden_state_t {CLEAR, RUN}.
- Sub-module rsp_lden32_dec: 5-to-32 active-low one-hot decoder with enable input and entry-0 suppression. Used for both the clear and the run paths.
- Top holds the FSM, ptr, starve_cnt, arbitration, and output registers.

## Test plan
- Reset release with no requests and no hold -> wr_ld_bar = ~(1<<n) for n=1..31 in cycles 1..31, wr_data=0, then all-ones; clr_done rises in cycle 32.
- RUN, su_req addr=5 data=32'hDEADBEEF -> su_gnt same cycle; next cycle wr_ld_bar=32'hFFFF_FFDF, wr_data=32'hDEADBEEF; following cycle all-ones.
- su and dma both requesting continuously (su addr 3, dma addr 7), STARVE_LIMIT=4 -> grant pattern su,su,su,su,dma repeating; wr_ld_bar alternates 32'hFFFF_FFF7 ×4 then 32'hFFFF_FF7F.
- dma_req addr=0 -> dma_gnt=1; wr_ld_bar stays 32'hFFFF_FFFF next cycle.
- hold pulsed for 3 cycles during RUN with su requesting:
  - no grants and all-ones wr_ld_bar during hold;
  - starve_cnt unchanged;
  - su granted on the first cycle after hold drops.
- reset_l asserted at cycle 10 of the clear, then released -> wr_ld_bar all-ones immediately; walk restarts at entry 1; clr_done=0 until 31 cycles after release.
